xif_outstanding_bridge: RTL and testbench
=========================================

# xif_outstanding_bridge

Parametrised CORE-V-XIF bridge between a core-side issue/commit/result port and a coprocessor-side port. It supports up to `MAX_OUTSTANDING` in-flight offloaded instructions, in place of the single-instruction direct translation. It tracks every accepted instruction in an ID table, honours the coprocessor's `register_read` request, pipelines commits, and buffers results in a FIFO. It sits between the CPU wrapper and the XIF coprocessor in `core_v_mini_mcu`.

## Interface
Parameters:
- `ID_WIDTH`, 4: instruction ID width.
- `MAX_OUTSTANDING`, 4: ID table entries, ≥1.
- `RESULT_DEPTH`, 2: result FIFO depth, ≥1.
- `NUM_RS`, 2: source operands, 2 or 3.
- `DATA_W`, 32: operand/result width.

Ports:
- `clk_i` in 1: clock.
- `rst_i` in 1: synchronous, active-high reset.
- `core_issue_valid_i` in 1 / `core_issue_ready_o` out 1: core issue handshake.
- `core_issue_instr_i` in 32, `core_issue_id_i` in ID_WIDTH: offloaded instruction and its ID.
- `core_rs_i` in NUM_RS*DATA_W, `core_rs_valid_i` in NUM_RS: operands and per-operand valid.
- `core_issue_accept_o` out 1, `core_issue_writeback_o` out 1: issue response.
- `core_commit_valid_i` in 1, `core_commit_id_i` in ID_WIDTH, `core_commit_kill_i` in 1: commit.
- `core_result_valid_o` out 1 / `core_result_ready_i` in 1: result handshake.
- `core_result_id_o` out ID_WIDTH, `core_result_data_o` out DATA_W, `core_result_rd_o` out 5, `core_result_we_o` out 1: result payload.
- `cop_issue_valid_o` out 1 / `cop_issue_ready_i` in 1: coprocessor issue handshake.
- `cop_issue_instr_o` out 32, `cop_issue_id_o` out ID_WIDTH, `cop_rs_o` out NUM_RS*DATA_W, `cop_rs_valid_o` out NUM_RS: forwarded issue.
- `cop_issue_accept_i` in 1, `cop_issue_writeback_i` in 1, `cop_issue_register_read_i` in NUM_RS: coprocessor response.
- `cop_commit_valid_o` out 1, `cop_commit_id_o` out ID_WIDTH, `cop_commit_kill_o` out 1: registered commit.
- `cop_result_valid_i` in 1 / `cop_result_ready_o` out 1, `cop_result_id_i` in ID_WIDTH, `cop_result_data_i` in DATA_W, `cop_result_rd_i` in 5, `cop_result_we_i` in 1: coprocessor result.
- `outstanding_o` out $clog2(MAX_OUTSTANDING+1): occupied table entries.
- `err_o` out 1: sticky protocol error.

## Operation
- Each ID table entry holds `valid`, `id`, `writeback`, `committed`.
- Issue gate: `gate = !full && !id_in_use(core_issue_id_i) && &(core_rs_valid_i | ~cop_issue_register_read_i)`.
  - `cop_issue_valid_o = core_issue_valid_i && !full && !id_in_use`.
  - `core_issue_ready_o = cop_issue_ready_i && gate`.
  - Instr, ID and rs pass through combinationally. Accept and writeback pass through.
- Issue handshake (`core_issue_valid_i && core_issue_ready_o`):
  - If `cop_issue_accept_i=1`, allocate the lowest free entry with `committed=0`.
  - If not accepted, allocate nothing.
- Commit for an ID present in the table:
  - `kill=1` → free the entry.
  - `kill=0` and `writeback=0` → free the entry.
  - Otherwise → set `committed`.
- Commit for an unknown ID sets `err_o`.
- Commit is registered and presented on `cop_commit_*` one cycle later as a single-cycle pulse.
- Result push (`cop_result_valid_i && cop_result_ready_o`), where `cop_result_ready_o = !fifo_full`:
  - Matching entry that is valid, committed and writeback → free the entry and push into the FIFO.
  - Anything else → drop the result and set `err_o`.
- `core_result_*` is driven from the FIFO head. A pop occurs on `core_result_valid_o && core_result_ready_i`.
- Reset values: table cleared, FIFO empty, `err_o=0`, `outstanding_o=0`, all `*_valid_o=0`, `cop_commit_*=0`.
  - A reset mid-operation discards all entries and buffered results without emitting them.
  - Only `rst_i` clears `err_o`.

## Timing
- Issue path: 0-cycle combinational.
- Commit: 1-cycle latency to the coprocessor.
- Result: core-side valid appears at earliest 1 cycle after the coprocessor-side handshake. The FIFO is registered with no bypass.
- Full/free evaluation:
  - `full` and `id_in_use` are evaluated on current-cycle state.
  - An entry freed in cycle N can be reallocated in cycle N+1, not in N.
  - Allocate and free in the same cycle both take effect; `outstanding_o` reflects the net change next cycle.
- FIFO full: `cop_result_ready_o=0`. A same-cycle pop does not enable a push.
- FIFO: simultaneous push and pop when not full keeps the count unchanged.
- A result arriving in the same cycle as the commit of its ID is an error, because the entry is not yet committed.
- Protocol rule: the core's `core_issue_*` must be held stable while valid and not ready.

## Structure
- Package `xif_bridge_pkg`:
  - `xif_entry_t` (valid, id, writeback, committed).
  - `xif_result_t` (id, data, rd, we).
  - Width constants derived from the parameters.
- Sub-module `xif_result_fifo`: parametrised synchronous FIFO of `xif_result_t`, `RESULT_DEPTH` deep, with full/empty flags.
- Top level contains the ID table, the lookup/priority-encoder logic, the commit register and the error flag.

## Test plan
- **Issue and accept:** issue ID 3 with rs_valid=2'b11, accept=1, writeback=1 → handshake completes the same cycle, `outstanding_o=1`. Commit ID 3 (kill=0) → `cop_commit_valid_o` pulses the next cycle. Result ID 3 with data 0xDEADBEEF → core result 0xDEADBEEF at +1 cycle, `outstanding_o=0`.
- **Table full:** fill 4 IDs (0..3) → issue of ID 4 sees `core_issue_ready_o=0`. Commit kill of ID 1 → ID 4 is accepted exactly one cycle after the free.
- **Register read:** `register_read=2'b10` with `rs_valid=2'b01` → ready held at 0. Raising `rs_valid[1]` → issue completes the same cycle.
- **Result backpressure:** RESULT_DEPTH=2, `core_result_ready_i=0`, 3 committed results → `cop_result_ready_o=0` after 2 pushes. Releasing ready → results are delivered in order.
- **Errors:** a result for an uncommitted ID 5 → dropped and `err_o=1`, staying high until `rst_i`. A reset with 2 entries outstanding → `outstanding_o=0` and no `core_result_valid_o` afterwards.
- **Duplicate ID:** an issue with an ID already in flight → stalled until that entry frees.

Source files
------------

// File: rtl/xif_bridge_pkg.sv
// Shared types and width helpers for the CORE-V-XIF outstanding bridge.
package xif_bridge_pkg;

  localparam int unsigned XIF_ID_W   = 4;
  localparam int unsigned XIF_DATA_W = 32;
  localparam int unsigned XIF_RD_W   = 5;

  typedef struct packed {
    logic                valid;
    logic [XIF_ID_W-1:0] id;
    logic                writeback;
    logic                committed;
  } xif_entry_t;

  typedef struct packed {
    logic [XIF_ID_W-1:0]   id;
    logic [XIF_DATA_W-1:0] data;
    logic [XIF_RD_W-1:0]   rd;
    logic                  we;
  } xif_result_t;

  // Index width that stays legal for a single-entry structure.
  function automatic int unsigned idx_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/xif_result_fifo.sv
// Registered result FIFO; a pop in a full cycle never frees room for a same-cycle push.
module xif_result_fifo
  import xif_bridge_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        push_i,
  input  xif_result_t data_i,
  input  logic        pop_i,
  output xif_result_t data_o,
  output logic        full_o,
  output logic        empty_o
);

  localparam int unsigned PW = idx_w(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  xif_result_t     mem_q [DEPTH];
  logic [PW-1:0]   wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            do_push, do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign data_o  = mem_q[rd_q];

  always_comb begin
    wr_d  = do_push ? ptr_inc(wr_q) : wr_q;
    rd_d  = do_pop ? ptr_inc(rd_q) : rd_q;
    cnt_d = cnt_q;
    if (do_push && !do_pop) cnt_d = cnt_q + CW'(1);
    else if (!do_push && do_pop) cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end

endmodule

// File: rtl/xif_outstanding_bridge.sv
// CORE-V-XIF bridge tracking up to MAX_OUTSTANDING offloaded instructions,
// with registered commit forwarding and a buffered result path.
module xif_outstanding_bridge
  import xif_bridge_pkg::*;
#(
  parameter int unsigned ID_WIDTH        = XIF_ID_W,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned RESULT_DEPTH    = 2,
  parameter int unsigned NUM_RS          = 2,
  parameter int unsigned DATA_W          = XIF_DATA_W
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic                                 core_issue_valid_i,
  output logic                                 core_issue_ready_o,
  input  logic [31:0]                          core_issue_instr_i,
  input  logic [ID_WIDTH-1:0]                  core_issue_id_i,
  input  logic [NUM_RS*DATA_W-1:0]             core_rs_i,
  input  logic [NUM_RS-1:0]                    core_rs_valid_i,
  output logic                                 core_issue_accept_o,
  output logic                                 core_issue_writeback_o,
  input  logic                                 core_commit_valid_i,
  input  logic [ID_WIDTH-1:0]                  core_commit_id_i,
  input  logic                                 core_commit_kill_i,
  output logic                                 core_result_valid_o,
  input  logic                                 core_result_ready_i,
  output logic [ID_WIDTH-1:0]                  core_result_id_o,
  output logic [DATA_W-1:0]                    core_result_data_o,
  output logic [4:0]                           core_result_rd_o,
  output logic                                 core_result_we_o,
  output logic                                 cop_issue_valid_o,
  input  logic                                 cop_issue_ready_i,
  output logic [31:0]                          cop_issue_instr_o,
  output logic [ID_WIDTH-1:0]                  cop_issue_id_o,
  output logic [NUM_RS*DATA_W-1:0]             cop_rs_o,
  output logic [NUM_RS-1:0]                    cop_rs_valid_o,
  input  logic                                 cop_issue_accept_i,
  input  logic                                 cop_issue_writeback_i,
  input  logic [NUM_RS-1:0]                    cop_issue_register_read_i,
  output logic                                 cop_commit_valid_o,
  output logic [ID_WIDTH-1:0]                  cop_commit_id_o,
  output logic                                 cop_commit_kill_o,
  input  logic                                 cop_result_valid_i,
  output logic                                 cop_result_ready_o,
  input  logic [ID_WIDTH-1:0]                  cop_result_id_i,
  input  logic [DATA_W-1:0]                    cop_result_data_i,
  input  logic [4:0]                           cop_result_rd_i,
  input  logic                                 cop_result_we_i,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_o,
  output logic                                 err_o
);

  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned IDX_W = idx_w(MAX_OUTSTANDING);

  xif_entry_t          tbl_q [MAX_OUTSTANDING];
  xif_entry_t          tbl_d [MAX_OUTSTANDING];
  logic                err_q, err_d;
  logic                cmt_valid_q, cmt_kill_q;
  logic [ID_WIDTH-1:0] cmt_id_q;

  logic                full, id_in_use, free_found, cm_hit, rs_hit, rs_ok;
  logic [IDX_W-1:0]    free_idx, cm_idx, rs_idx;
  logic [CNT_W-1:0]    cnt;
  logic                gate, alloc, res_hs, fifo_push, fifo_full, fifo_empty;
  xif_result_t         fifo_in, fifo_out;

  // Table lookups on current-cycle state only; IDs in the table are unique.
  always_comb begin
    full       = 1'b1;
    id_in_use  = 1'b0;
    free_found = 1'b0;
    free_idx   = '0;
    cm_hit     = 1'b0;
    cm_idx     = '0;
    rs_hit     = 1'b0;
    rs_idx     = '0;
    cnt        = '0;
    for (int unsigned i = 0; i < MAX_OUTSTANDING; i++) begin
      if (tbl_q[i].valid) begin
        cnt = cnt + CNT_W'(1);
        if (tbl_q[i].id == core_issue_id_i) id_in_use = 1'b1;
        if (!cm_hit && tbl_q[i].id == core_commit_id_i) begin
          cm_hit = 1'b1;
          cm_idx = IDX_W'(i);
        end
        if (!rs_hit && tbl_q[i].id == cop_result_id_i) begin
          rs_hit = 1'b1;
          rs_idx = IDX_W'(i);
        end
      end else begin
        full = 1'b0;
        if (!free_found) begin
          free_found = 1'b1;
          free_idx   = IDX_W'(i);
        end
      end
    end
  end

  assign rs_ok = rs_hit && tbl_q[rs_idx].committed && tbl_q[rs_idx].writeback;

  assign gate                   = !full && !id_in_use &&
                                  (&(core_rs_valid_i | ~cop_issue_register_read_i));
  assign cop_issue_valid_o      = core_issue_valid_i && !full && !id_in_use;
  assign core_issue_ready_o     = cop_issue_ready_i && gate;
  assign cop_issue_instr_o      = core_issue_instr_i;
  assign cop_issue_id_o         = core_issue_id_i;
  assign cop_rs_o               = core_rs_i;
  assign cop_rs_valid_o         = core_rs_valid_i;
  assign core_issue_accept_o    = cop_issue_accept_i;
  assign core_issue_writeback_o = cop_issue_writeback_i;

  assign alloc              = core_issue_valid_i && core_issue_ready_o && cop_issue_accept_i;
  assign cop_result_ready_o = !fifo_full;
  assign res_hs             = cop_result_valid_i && cop_result_ready_o;
  assign fifo_push          = res_hs && rs_ok;

  // Allocation targets a free slot while commit/result touch valid slots, so all apply together.
  always_comb begin
    tbl_d = tbl_q;
    if (alloc) begin
      tbl_d[free_idx].valid     = 1'b1;
      tbl_d[free_idx].id        = core_issue_id_i;
      tbl_d[free_idx].writeback = cop_issue_writeback_i;
      tbl_d[free_idx].committed = 1'b0;
    end
    if (core_commit_valid_i && cm_hit) begin
      if (core_commit_kill_i || !tbl_q[cm_idx].writeback) tbl_d[cm_idx] = '0;
      else tbl_d[cm_idx].committed = 1'b1;
    end
    if (fifo_push) tbl_d[rs_idx] = '0;
  end

  assign err_d = err_q || (core_commit_valid_i && !cm_hit) || (res_hs && !rs_ok);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tbl_q       <= '{default: '0};
      err_q       <= 1'b0;
      cmt_valid_q <= 1'b0;
      cmt_id_q    <= '0;
      cmt_kill_q  <= 1'b0;
    end else begin
      tbl_q       <= tbl_d;
      err_q       <= err_d;
      cmt_valid_q <= core_commit_valid_i;
      cmt_id_q    <= core_commit_valid_i ? core_commit_id_i : '0;
      cmt_kill_q  <= core_commit_valid_i && core_commit_kill_i;
    end
  end

  assign fifo_in = '{id: cop_result_id_i, data: cop_result_data_i,
                     rd: cop_result_rd_i, we: cop_result_we_i};

  xif_result_fifo #(
    .DEPTH (RESULT_DEPTH)
  ) u_result_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (fifo_push),
    .data_i  (fifo_in),
    .pop_i   (core_result_ready_i),
    .data_o  (fifo_out),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign core_result_valid_o = !fifo_empty;
  assign core_result_id_o    = fifo_out.id;
  assign core_result_data_o  = fifo_out.data;
  assign core_result_rd_o    = fifo_out.rd;
  assign core_result_we_o    = fifo_out.we;

  assign cop_commit_valid_o = cmt_valid_q;
  assign cop_commit_id_o    = cmt_id_q;
  assign cop_commit_kill_o  = cmt_kill_q;
  assign outstanding_o      = cnt;
  assign err_o              = err_q;

endmodule

// File: tb/tb_xif_outstanding_bridge.sv
// Directed self-checking bench for xif_outstanding_bridge at default parameters.
module tb_xif_outstanding_bridge;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        core_issue_valid_i;
  logic        core_issue_ready_o;
  logic [31:0] core_issue_instr_i;
  logic [3:0]  core_issue_id_i;
  logic [63:0] core_rs_i;
  logic [1:0]  core_rs_valid_i;
  logic        core_issue_accept_o;
  logic        core_issue_writeback_o;
  logic        core_commit_valid_i;
  logic [3:0]  core_commit_id_i;
  logic        core_commit_kill_i;
  logic        core_result_valid_o;
  logic        core_result_ready_i;
  logic [3:0]  core_result_id_o;
  logic [31:0] core_result_data_o;
  logic [4:0]  core_result_rd_o;
  logic        core_result_we_o;
  logic        cop_issue_valid_o;
  logic        cop_issue_ready_i;
  logic [31:0] cop_issue_instr_o;
  logic [3:0]  cop_issue_id_o;
  logic [63:0] cop_rs_o;
  logic [1:0]  cop_rs_valid_o;
  logic        cop_issue_accept_i;
  logic        cop_issue_writeback_i;
  logic [1:0]  cop_issue_register_read_i;
  logic        cop_commit_valid_o;
  logic [3:0]  cop_commit_id_o;
  logic        cop_commit_kill_o;
  logic        cop_result_valid_i;
  logic        cop_result_ready_o;
  logic [3:0]  cop_result_id_i;
  logic [31:0] cop_result_data_i;
  logic [4:0]  cop_result_rd_i;
  logic        cop_result_we_i;
  logic [2:0]  outstanding_o;
  logic        err_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  xif_outstanding_bridge #(
    .ID_WIDTH        (4),
    .MAX_OUTSTANDING (4),
    .RESULT_DEPTH    (2),
    .NUM_RS          (2),
    .DATA_W          (32)
  ) dut (
    .clk_i                     (clk),
    .rst_i                     (rst_i),
    .core_issue_valid_i        (core_issue_valid_i),
    .core_issue_ready_o        (core_issue_ready_o),
    .core_issue_instr_i        (core_issue_instr_i),
    .core_issue_id_i           (core_issue_id_i),
    .core_rs_i                 (core_rs_i),
    .core_rs_valid_i           (core_rs_valid_i),
    .core_issue_accept_o       (core_issue_accept_o),
    .core_issue_writeback_o    (core_issue_writeback_o),
    .core_commit_valid_i       (core_commit_valid_i),
    .core_commit_id_i          (core_commit_id_i),
    .core_commit_kill_i        (core_commit_kill_i),
    .core_result_valid_o       (core_result_valid_o),
    .core_result_ready_i       (core_result_ready_i),
    .core_result_id_o          (core_result_id_o),
    .core_result_data_o        (core_result_data_o),
    .core_result_rd_o          (core_result_rd_o),
    .core_result_we_o          (core_result_we_o),
    .cop_issue_valid_o         (cop_issue_valid_o),
    .cop_issue_ready_i         (cop_issue_ready_i),
    .cop_issue_instr_o         (cop_issue_instr_o),
    .cop_issue_id_o            (cop_issue_id_o),
    .cop_rs_o                  (cop_rs_o),
    .cop_rs_valid_o            (cop_rs_valid_o),
    .cop_issue_accept_i        (cop_issue_accept_i),
    .cop_issue_writeback_i     (cop_issue_writeback_i),
    .cop_issue_register_read_i (cop_issue_register_read_i),
    .cop_commit_valid_o        (cop_commit_valid_o),
    .cop_commit_id_o           (cop_commit_id_o),
    .cop_commit_kill_o         (cop_commit_kill_o),
    .cop_result_valid_i        (cop_result_valid_i),
    .cop_result_ready_o        (cop_result_ready_o),
    .cop_result_id_i           (cop_result_id_i),
    .cop_result_data_i         (cop_result_data_i),
    .cop_result_rd_i           (cop_result_rd_i),
    .cop_result_we_i           (cop_result_we_i),
    .outstanding_o             (outstanding_o),
    .err_o                     (err_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] id);
    core_issue_valid_i = 1'b1;
    core_issue_id_i    = id;
    core_issue_instr_i = {28'h00AB000, id};
    core_rs_valid_i    = 2'b11;
    #1;
    chk("issue_ready", 32'(core_issue_ready_o), 32'd1);
    step();
    core_issue_valid_i = 1'b0;
  endtask

  task automatic commit(input logic [3:0] id, input logic kill);
    core_commit_valid_i = 1'b1;
    core_commit_id_i    = id;
    core_commit_kill_i  = kill;
    step();
    core_commit_valid_i = 1'b0;
    core_commit_kill_i  = 1'b0;
  endtask

  task automatic result(input logic [3:0] id, input logic [31:0] data);
    cop_result_valid_i = 1'b1;
    cop_result_id_i    = id;
    cop_result_data_i  = data;
    cop_result_rd_i    = 5'd7;
    cop_result_we_i    = 1'b1;
    step();
    cop_result_valid_i = 1'b0;
  endtask

  initial begin
    rst_i                     = 1'b1;
    core_issue_valid_i        = 1'b0;
    core_issue_instr_i        = '0;
    core_issue_id_i           = '0;
    core_rs_i                 = 64'h1111_2222_3333_4444;
    core_rs_valid_i           = 2'b11;
    core_commit_valid_i       = 1'b0;
    core_commit_id_i          = '0;
    core_commit_kill_i        = 1'b0;
    core_result_ready_i       = 1'b1;
    cop_issue_ready_i         = 1'b1;
    cop_issue_accept_i        = 1'b1;
    cop_issue_writeback_i     = 1'b1;
    cop_issue_register_read_i = 2'b00;
    cop_result_valid_i        = 1'b0;
    cop_result_id_i           = '0;
    cop_result_data_i         = '0;
    cop_result_rd_i           = '0;
    cop_result_we_i           = 1'b0;
    step();
    step();
    rst_i = 1'b0;
    chk("rst_outstanding", 32'(outstanding_o), 32'd0);
    chk("rst_err", 32'(err_o), 32'd0);
    chk("rst_res_valid", 32'(core_result_valid_o), 32'd0);
    chk("rst_commit_valid", 32'(cop_commit_valid_o), 32'd0);

    // Issue, commit and result for ID 3.
    core_issue_valid_i = 1'b1;
    core_issue_id_i    = 4'd3;
    core_issue_instr_i = 32'h0000_300B;
    #1;
    chk("t1_ready", 32'(core_issue_ready_o), 32'd1);
    chk("t1_cop_valid", 32'(cop_issue_valid_o), 32'd1);
    chk("t1_cop_id", 32'(cop_issue_id_o), 32'd3);
    chk("t1_cop_instr", cop_issue_instr_o, 32'h0000_300B);
    chk("t1_accept", 32'(core_issue_accept_o), 32'd1);
    step();
    core_issue_valid_i = 1'b0;
    chk("t1_outstanding", 32'(outstanding_o), 32'd1);
    commit(4'd3, 1'b0);
    chk("t1_cmt_valid", 32'(cop_commit_valid_o), 32'd1);
    chk("t1_cmt_id", 32'(cop_commit_id_o), 32'd3);
    chk("t1_cmt_kill", 32'(cop_commit_kill_o), 32'd0);
    chk("t1_outst_cmt", 32'(outstanding_o), 32'd1);
    step();
    chk("t1_cmt_pulse", 32'(cop_commit_valid_o), 32'd0);
    cop_result_valid_i = 1'b1;
    cop_result_id_i    = 4'd3;
    cop_result_data_i  = 32'hDEADBEEF;
    cop_result_rd_i    = 5'd9;
    cop_result_we_i    = 1'b1;
    #1;
    chk("t1_cop_res_ready", 32'(cop_result_ready_o), 32'd1);
    chk("t1_no_bypass", 32'(core_result_valid_o), 32'd0);
    step();
    cop_result_valid_i = 1'b0;
    chk("t1_res_valid", 32'(core_result_valid_o), 32'd1);
    chk("t1_res_data", core_result_data_o, 32'hDEADBEEF);
    chk("t1_res_id", 32'(core_result_id_o), 32'd3);
    chk("t1_res_rd", 32'(core_result_rd_o), 32'd9);
    chk("t1_outst_done", 32'(outstanding_o), 32'd0);
    step();
    chk("t1_res_popped", 32'(core_result_valid_o), 32'd0);

    // Table full, reallocation one cycle after a free, duplicate ID stall.
    for (int i = 0; i < 4; i++) issue(4'(i));
    chk("t2_full_cnt", 32'(outstanding_o), 32'd4);
    core_issue_valid_i  = 1'b1;
    core_issue_id_i     = 4'd4;
    core_commit_valid_i = 1'b1;
    core_commit_id_i    = 4'd1;
    core_commit_kill_i  = 1'b1;
    #1;
    chk("t2_full_ready", 32'(core_issue_ready_o), 32'd0);
    chk("t2_full_copv", 32'(cop_issue_valid_o), 32'd0);
    step();
    core_commit_valid_i = 1'b0;
    core_commit_kill_i  = 1'b0;
    chk("t2_after_free_ready", 32'(core_issue_ready_o), 32'd1);
    chk("t2_kill_fwd", 32'(cop_commit_kill_o), 32'd1);
    step();
    core_issue_valid_i = 1'b0;
    chk("t2_realloc_cnt", 32'(outstanding_o), 32'd4);
    commit(4'd0, 1'b1);
    chk("t2_cnt3", 32'(outstanding_o), 32'd3);
    core_issue_valid_i  = 1'b1;
    core_issue_id_i     = 4'd2;
    core_commit_valid_i = 1'b1;
    core_commit_id_i    = 4'd2;
    core_commit_kill_i  = 1'b1;
    #1;
    chk("t2_dup_ready", 32'(core_issue_ready_o), 32'd0);
    chk("t2_dup_copv", 32'(cop_issue_valid_o), 32'd0);
    step();
    core_commit_valid_i = 1'b0;
    core_commit_kill_i  = 1'b0;
    chk("t2_dup_freed_ready", 32'(core_issue_ready_o), 32'd1);
    step();
    core_issue_valid_i = 1'b0;
    chk("t2_dup_cnt", 32'(outstanding_o), 32'd3);
    commit(4'd2, 1'b1);
    commit(4'd3, 1'b1);
    commit(4'd4, 1'b1);
    chk("t2_empty", 32'(outstanding_o), 32'd0);
    chk("t2_err", 32'(err_o), 32'd0);

    // Register-read gating.
    cop_issue_register_read_i = 2'b10;
    core_rs_valid_i           = 2'b01;
    core_issue_valid_i        = 1'b1;
    core_issue_id_i           = 4'd5;
    #1;
    chk("t3_rr_ready", 32'(core_issue_ready_o), 32'd0);
    chk("t3_rr_copv", 32'(cop_issue_valid_o), 32'd1);
    step();
    chk("t3_rr_cnt", 32'(outstanding_o), 32'd0);
    core_rs_valid_i = 2'b11;
    #1;
    chk("t3_rr_go", 32'(core_issue_ready_o), 32'd1);
    step();
    core_issue_valid_i        = 1'b0;
    cop_issue_register_read_i = 2'b00;
    chk("t3_cnt", 32'(outstanding_o), 32'd1);
    commit(4'd5, 1'b1);
    chk("t3_cnt0", 32'(outstanding_o), 32'd0);

    // Result backpressure with a 2-deep FIFO.
    core_result_ready_i = 1'b0;
    issue(4'd6);
    issue(4'd7);
    issue(4'd8);
    commit(4'd6, 1'b0);
    commit(4'd7, 1'b0);
    commit(4'd8, 1'b0);
    result(4'd6, 32'hA0A0_0006);
    result(4'd7, 32'hB0B0_0007);
    cop_result_valid_i = 1'b1;
    cop_result_id_i    = 4'd8;
    cop_result_data_i  = 32'hC0C0_0008;
    #1;
    chk("t4_full_ready", 32'(cop_result_ready_o), 32'd0);
    step();
    chk("t4_held_cnt", 32'(outstanding_o), 32'd1);
    chk("t4_head6", core_result_data_o, 32'hA0A0_0006);
    core_result_ready_i = 1'b1;
    #1;
    chk("t4_pop_no_push", 32'(cop_result_ready_o), 32'd0);
    step();
    chk("t4_head7", core_result_data_o, 32'hB0B0_0007);
    chk("t4_ready_back", 32'(cop_result_ready_o), 32'd1);
    step();
    cop_result_valid_i = 1'b0;
    chk("t4_head8_id", 32'(core_result_id_o), 32'd8);
    chk("t4_head8", core_result_data_o, 32'hC0C0_0008);
    chk("t4_cnt0", 32'(outstanding_o), 32'd0);
    step();
    chk("t4_drained", 32'(core_result_valid_o), 32'd0);
    chk("t4_err", 32'(err_o), 32'd0);

    // Errors and reset with work in flight.
    issue(4'd5);
    result(4'd5, 32'h1234_5678);
    chk("t5_err", 32'(err_o), 32'd1);
    chk("t5_dropped", 32'(core_result_valid_o), 32'd0);
    chk("t5_cnt", 32'(outstanding_o), 32'd1);
    step();
    step();
    chk("t5_sticky", 32'(err_o), 32'd1);
    core_result_ready_i = 1'b0;
    issue(4'd9);
    commit(4'd9, 1'b0);
    result(4'd9, 32'h0000_0055);
    chk("t5_buffered", 32'(core_result_valid_o), 32'd1);
    issue(4'd10);
    chk("t5_cnt2", 32'(outstanding_o), 32'd2);
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    chk("t5_rst_cnt", 32'(outstanding_o), 32'd0);
    chk("t5_rst_err", 32'(err_o), 32'd0);
    chk("t5_rst_res", 32'(core_result_valid_o), 32'd0);
    core_result_ready_i = 1'b1;
    step();
    step();
    chk("t5_no_result", 32'(core_result_valid_o), 32'd0);
    chk("t5_cnt_after", 32'(outstanding_o), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
